// File: rtl/ahb_master_arb_pkg.sv
// Shared types and constants for the arbitrating AHB3-Lite master.
package ahb_master_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Phase fields are sized for the widest supported bus; narrower buses zero-extend.
  localparam int PH_ADDR_W = 64;
  localparam int PH_DATA_W = 64;
  localparam int PH_ID_W   = 2;

  typedef struct packed {
    logic                 valid;
    logic                 cancelled;
    logic                 write;
    logic [2:0]           size;
    logic [PH_ADDR_W-1:0] addr;
    logic [PH_DATA_W-1:0] wdata;
    logic [PH_ID_W-1:0]   id;
  } phase_t;

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the search start pointer moves only on an accepted grant.
module ahb_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_lite_master_arb.sv
// Round-robin arbitrating AHB3-Lite master issuing single transfers with pipelined address/data phases.
// Optional macro AHB_MASTER_ARB_TIMEOUT_EN adds a sticky wait-state watchdog output 'timeout'.
module ahb_lite_master_arb
  import ahb_master_arb_pkg::*;
#(
  parameter int HADDR_SIZE     = 32,
  parameter int HDATA_SIZE     = 32,
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*HADDR_SIZE-1:0] req_addr,
  input  logic [NREQ*HDATA_SIZE-1:0] req_wdata,
  input  logic [NREQ*3-1:0]       req_size,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [HDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    HSELx,
  output logic [HADDR_SIZE-1:0]   HADDR,
  output logic [HDATA_SIZE-1:0]   HWDATA,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [3:0]              HPROT,
  output logic [1:0]              HTRANS,
  output logic                    HREADY,
  input  logic                    HREADYOUT,
  input  logic                    HRESP,
  input  logic [HDATA_SIZE-1:0]   HRDATA
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
  ,
  output logic                    timeout
`endif
);

  localparam int IW = $clog2(NREQ);

  phase_t          ap, dp, ap_next;
  logic            ap_issue, ap_free, any_req;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            unused_bits;

  ahb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .req       (req_valid),
    .advance   (ap_free),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // A cancelled AP is held as the replay, so it is never free to reload.
  assign ap_issue  = ap.valid && !ap.cancelled;
  assign ap_free   = !ap.valid || (HREADYOUT && !ap.cancelled);
  assign req_ready = ap_free ? grant : '0;

  always_comb begin
    ap_next = ap;
    if (ap_free) begin
      ap_next = '0;
      if (any_req) begin
        ap_next.valid = 1'b1;
        ap_next.write = req_write[grant_idx];
        ap_next.size  = req_size[grant_idx*3 +: 3];
        ap_next.addr  = PH_ADDR_W'(req_addr[grant_idx*HADDR_SIZE +: HADDR_SIZE]);
        ap_next.wdata = PH_DATA_W'(req_wdata[grant_idx*HDATA_SIZE +: HDATA_SIZE]);
        ap_next.id    = PH_ID_W'(grant_idx);
      end
    end else if (HREADYOUT) begin
      ap_next.cancelled = 1'b0;
    end
    // First error cycle: whatever AP holds next cycle must go out as IDLE.
    if (ap_next.valid && HRESP && !HREADYOUT) ap_next.cancelled = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap        <= '0;
      dp        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ap <= ap_next;
      if (HREADYOUT) begin
        dp        <= ap_issue ? ap : '0;
        rsp_valid <= dp.valid;
        if (dp.valid) begin
          rsp_rdata <= HRDATA;
          rsp_err   <= HRESP;
          rsp_id    <= dp.id[IW-1:0];
        end
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign HSELx       = ap.valid;
  assign HADDR       = ap.addr[HADDR_SIZE-1:0];
  assign HWRITE      = ap.write;
  assign HSIZE       = ap.size;
  assign HTRANS      = ap_issue ? NONSEQ : IDLE;
  assign HWDATA      = dp.wdata[HDATA_SIZE-1:0];
  assign HBURST      = HBURST_SINGLE;
  assign HPROT       = HPROT_DEFAULT;
  assign HREADY      = HREADYOUT;
  assign unused_bits = ^{ap, dp};

`ifdef AHB_MASTER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (HREADYOUT) begin
      wait_cnt <= '0;
    end else if ((ap.valid || dp.valid) && wait_cnt != TW'(TIMEOUT_CYCLES)) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Directed bench for ahb_lite_master_arb (NREQ=2, 32-bit buses); timeout scenario built only with AHB_MASTER_ARB_TIMEOUT_EN.
module tb_ahb_lite_master_arb;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [5:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_rdata;
  logic        HSELx, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_count = 0;
  int ready1_count = 0;

  ahb_lite_master_arb #(.HADDR_SIZE(32), .HDATA_SIZE(32), .NREQ(2), .TIMEOUT_CYCLES(64)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSELx(HSELx), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) rsp_count++;
    if (req_ready[1] === 1'b1) ready1_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_size[i*3 +: 3]    = 3'd2;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_htrans: got %b expected 00", HTRANS); end
    n_checks++; if (HSELx !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_hsel: got %b expected 0", HSELx); end
    n_checks++; if (HADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_haddr: got %h expected 0", HADDR); end
    n_checks++; if (HWDATA !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_hwdata: got %h expected 0", HWDATA); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    tick();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_ready: got %b expected 00", req_ready); end
    n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_idle: got %b expected 00", HTRANS); end
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL sw_ready: got %b expected 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    #1;
    n_checks++; if (HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL sw_htrans: got %b expected 10", HTRANS); end
    n_checks++; if (HADDR !== 32'h100) begin n_fail++; $display("[TB] FAIL sw_haddr: got %h expected 100", HADDR); end
    n_checks++; if (HWRITE !== 1'b1 || HSIZE !== 3'd2 || HSELx !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_ctrl: got w=%b s=%0d sel=%b expected w=1 s=2 sel=1", HWRITE, HSIZE, HSELx); end
    n_checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin n_fail++; $display("[TB] FAIL sw_burst_prot: got %b/%b expected 000/0011", HBURST, HPROT); end
    tick();
    n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL sw_idle_after: got %b expected 00", HTRANS); end
    n_checks++; if (HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL sw_hwdata: got %h expected deadbeef", HWDATA); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_rsp_early: got %b expected 0", rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_rsp: got v=%b id=%0d err=%b expected v=1 id=0 err=0", rsp_valid, rsp_id, rsp_err); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_rsp_pulse: got %b expected 0", rsp_valid); end
  endtask

  // Pointer points past requester 0 after the single write, so grants go 1,0,1,0,...
  task automatic test_contention();
    int c0, c1, base;
    logic [1:0]  exp_gnt;
    logic [31:0] prev_addr;
    c0 = 0; c1 = 0; prev_addr = 32'h0; base = rsp_count;
    for (int k = 0; k < 8; k++) begin
      set_req(0, c0 < 4, 1'b1, 32'h1000 + 32'(4*c0), 32'hA000_0000 + 32'(c0));
      set_req(1, c1 < 4, 1'b1, 32'h2000 + 32'(4*c1), 32'hB000_0000 + 32'(c1));
      #1;
      exp_gnt = (k % 2 == 0) ? 2'b10 : 2'b01;
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("[TB] FAIL cont_grant%0d: got %b expected %b", k, req_ready, exp_gnt); end
      if (k > 0) begin
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== prev_addr) begin n_fail++; $display("[TB] FAIL cont_bus%0d: got %b/%h expected 10/%h", k, HTRANS, HADDR, prev_addr); end
      end
      if (exp_gnt[0]) begin prev_addr = 32'h1000 + 32'(4*c0); c0++; end
      else begin prev_addr = 32'h2000 + 32'(4*c1); c1++; end
      tick();
    end
    req_valid = 2'b00;
    #1;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== prev_addr) begin n_fail++; $display("[TB] FAIL cont_last: got %b/%h expected 10/%h", HTRANS, HADDR, prev_addr); end
    repeat (4) tick();
    n_checks++; if (rsp_count - base !== 8) begin n_fail++; $display("[TB] FAIL cont_rsp_count: got %0d expected 8", rsp_count - base); end
  endtask

  task automatic test_wait_states();
    int hits;
    hits = 0;
    set_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL ws_ready0: got %b expected 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h204, 32'hCAFE_0001);
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL ws_ready1: got %b expected 10", req_ready); end
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h200 || HWRITE !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_addr_rd: got %b/%h/%b expected 10/200/0", HTRANS, HADDR, HWRITE); end
    tick();
    req_valid[1] = 1'b0;
    HREADYOUT = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (w == 3) begin HREADYOUT = 1'b1; HRDATA = 32'h1234; end
      #1;
      n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h204 || HWRITE !== 1'b1) begin n_fail++; $display("[TB] FAIL ws_hold%0d: got %b/%h/%b expected 10/204/1", w, HTRANS, HADDR, HWRITE); end
      n_checks++; if (HREADY !== HREADYOUT || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_wait%0d: got hready=%b rsp=%b expected hready=%b rsp=0", w, HREADY, rsp_valid, HREADYOUT); end
      tick();
    end
    HRDATA = 32'h0;
    #1;
    if (rsp_valid === 1'b1 && rsp_rdata === 32'h1234) hits++;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rdata !== 32'h1234 || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_rsp_rd: got v=%b id=%0d d=%h e=%b expected v=1 id=0 d=1234 e=0", rsp_valid, rsp_id, rsp_rdata, rsp_err); end
    n_checks++; if (HWDATA !== 32'hCAFE_0001 || HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL ws_wr_data: got %h/%b expected cafe0001/00", HWDATA, HTRANS); end
    tick();
    if (rsp_valid === 1'b1 && rsp_rdata === 32'h1234) hits++;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL ws_rsp_wr: got v=%b id=%0d d=%h expected v=1 id=1 d=0", rsp_valid, rsp_id, rsp_rdata); end
    tick();
    n_checks++; if (hits !== 1 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_once: got hits=%0d v=%b expected hits=1 v=0", hits, rsp_valid); end
  endtask

  task automatic test_error_replay();
    int base1;
    base1 = ready1_count;
    set_req(0, 1'b1, 1'b1, 32'h300, 32'h5555_AAAA);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL er_ready0: got %b expected 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h304, 32'h0);
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL er_ready1: got %b expected 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    HRESP = 1'b1; HREADYOUT = 1'b0;
    #1;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h304 || HWDATA !== 32'h5555_AAAA) begin n_fail++; $display("[TB] FAIL er_cycle1: got %b/%h/%h expected 10/304/5555aaaa", HTRANS, HADDR, HWDATA); end
    tick();
    HREADYOUT = 1'b1;
    #1;
    n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL er_cycle2_idle: got %b expected 00", HTRANS); end
    tick();
    HRESP = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL er_rsp: got v=%b id=%0d e=%b expected v=1 id=0 e=1", rsp_valid, rsp_id, rsp_err); end
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h304 || HWRITE !== 1'b0) begin n_fail++; $display("[TB] FAIL er_replay: got %b/%h/%b expected 10/304/0", HTRANS, HADDR, HWRITE); end
    tick();
    HRDATA = 32'h77;
    #1;
    n_checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL er_replay_dp: got %b/%b expected 00/0", HTRANS, rsp_valid); end
    tick();
    HRDATA = 32'h0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h77) begin n_fail++; $display("[TB] FAIL er_follow_rsp: got v=%b id=%0d e=%b d=%h expected v=1 id=1 e=0 d=77", rsp_valid, rsp_id, rsp_err, rsp_rdata); end
    n_checks++; if (ready1_count - base1 !== 1) begin n_fail++; $display("[TB] FAIL er_ready1_once: got %0d expected 1", ready1_count - base1); end
    tick();
  endtask

  task automatic test_protocol_violation();
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h0);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL pv_ready0: got %b expected 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h404, 32'h0BAD_F00D);
    tick();
    req_valid[1] = 1'b0;
    HRESP = 1'b1;
    #1;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h404) begin n_fail++; $display("[TB] FAIL pv_follower: got %b/%h expected 10/404", HTRANS, HADDR); end
    tick();
    HRESP = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL pv_rsp: got v=%b id=%0d e=%b expected v=1 id=0 e=1", rsp_valid, rsp_id, rsp_err); end
    n_checks++; if (HWDATA !== 32'h0BAD_F00D || HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL pv_no_cancel: got %h/%b expected 0badf00d/00", HWDATA, HTRANS); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL pv_follow_rsp: got v=%b id=%0d e=%b expected v=1 id=1 e=0", rsp_valid, rsp_id, rsp_err); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int base;
    set_req(1, 1'b1, 1'b1, 32'h500, 32'hABCD_0123);
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL rm_ready: got %b expected 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    HREADYOUT = 1'b0;
    #1;
    n_checks++; if (HWDATA !== 32'hABCD_0123) begin n_fail++; $display("[TB] FAIL rm_pre_hwdata: got %h expected abcd0123", HWDATA); end
    tick();
    #2 HRESETn = 1'b0;
    #1;
    n_checks++; if (HWDATA !== 32'h0 || HTRANS !== 2'b00 || HSELx !== 1'b0 || HADDR !== 32'h0 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_reset_outs: got wd=%h tr=%b sel=%b a=%h rv=%b expected all 0", HWDATA, HTRANS, HSELx, HADDR, rsp_valid); end
    base = rsp_count;
    tick();
    HREADYOUT = 1'b1;
    HRESETn = 1'b1;
    repeat (4) tick();
    n_checks++; if (rsp_count !== base || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_no_rsp: got %0d extra, v=%b expected 0 extra, v=0", rsp_count - base, rsp_valid); end
  endtask

`ifdef AHB_MASTER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL to_initial: got %b expected 0", timeout); end
    set_req(0, 1'b1, 1'b0, 32'h600, 32'h0);
    tick();
    req_valid[0] = 1'b0;
    tick();
    HREADYOUT = 1'b0;
    repeat (63) tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL to_63: got %b expected 0", timeout); end
    tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_64: got %b expected 1", timeout); end
    HREADYOUT = 1'b1;
    repeat (3) tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_sticky: got %b expected 1", timeout); end
  endtask
`endif

  initial begin
    HRESETn   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_wait_states();
    test_error_replay();
    test_protocol_violation();
    test_reset_mid_wait();
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
